// File: rtl/mpu_instr_queue.sv
// Host-side instruction FIFO feeding the MPU control FSM, issuing one single-cycle command at a time.
// Optional build macro QUEUE_NOP_FILTER_EN: when defined, any word whose valid field is not 2'b01 is handshaken but dropped.
module mpu_instr_queue #(
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned ISSUE_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               host_instr_in,
  input  logic                     host_instr_valid,
  output logic                     host_instr_ready,
  input  logic                     flush,
  input  logic                     fsm_busy,
  output logic [7:0]               host_instruction,
  output logic                     issue_strobe,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic                     queue_empty,
  output logic                     queue_full,
  output logic                     timeout_err
);

  localparam int unsigned AW          = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT    = (AW+1)'(DEPTH);
  localparam logic [7:0]  TIMEOUT_CNT = 8'(ISSUE_TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE} state_e;

  state_e        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          head_seen_q, head_seen_d;
  logic [7:0]    out_q, out_d;
  logic [7:0]    timer_q, timer_d;
  logic          err_q, err_d;
  logic          accept, push, pop;

  assign queue_count      = count_q;
  assign queue_empty      = (count_q == '0);
  assign queue_full       = (count_q == FULL_CNT);
  assign host_instr_ready = !queue_full;
  assign accept           = host_instr_valid && host_instr_ready;

`ifdef QUEUE_NOP_FILTER_EN
  assign push = accept && !flush && (host_instr_in[3:2] == 2'b01);
`else
  assign push = accept && !flush;
`endif

  assign issue_strobe     = (state_q == S_ISSUE);
  assign host_instruction = issue_strobe ? out_q : '0;
  assign timeout_err      = err_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= host_instr_in;
  end

  // Head must be seen non-empty for a full cycle before it may pop (push-to-issue = 2 edges).
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    head_seen_d = !queue_empty;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      head_seen_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    err_d   = err_q;
    out_d   = out_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!queue_empty && head_seen_q && !fsm_busy && !flush) begin
          pop     = 1'b1;
          out_d   = mem_q[rd_ptr_q];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (fsm_busy) begin
          state_d = S_WAIT_DONE;
        end else begin
          timer_d = timer_q + 8'd1;
          if (timer_d == TIMEOUT_CNT) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!fsm_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      head_seen_q <= 1'b0;
      out_q       <= '0;
      timer_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      head_seen_q <= head_seen_d;
      out_q       <= out_d;
      timer_q     <= timer_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_mpu_instr_queue.sv
// Directed bench for mpu_instr_queue with a small control-FSM busy model and an issue monitor.
module tb_mpu_instr_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TO    = 15;
  localparam int NEVER   = 0;
  localparam int HOLD    = 1;
  localparam int RESPOND = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] host_instr_in;
  logic       host_instr_valid;
  logic       host_instr_ready;
  logic       flush;
  logic       fsm_busy;
  logic [7:0] host_instruction;
  logic       issue_strobe;
  logic [3:0] queue_count;
  logic       queue_empty;
  logic       queue_full;
  logic       timeout_err;

  int n_checks  = 0;
  int n_errors  = 0;
  int cyc       = 0;
  int busy_mode = RESPOND;
  int resp_from = -100;
  int nop_viol  = 0;
  int busy_viol = 0;
  logic busy_before = 1'b0;
  logic [7:0] issued_w[$];
  int         issued_c[$];

  mpu_instr_queue #(.DEPTH(DEPTH), .ISSUE_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .host_instr_in(host_instr_in),
    .host_instr_valid(host_instr_valid), .host_instr_ready(host_instr_ready),
    .flush(flush), .fsm_busy(fsm_busy), .host_instruction(host_instruction),
    .issue_strobe(issue_strobe), .queue_count(queue_count), .queue_empty(queue_empty),
    .queue_full(queue_full), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor plus control-FSM model: busy rises 1 cycle after a real issue and holds 4 cycles.
  initial begin
    fsm_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (issue_strobe) begin
        issued_w.push_back(host_instruction);
        issued_c.push_back(cyc);
        if (busy_before) busy_viol++;
        if (host_instruction[3:2] == 2'b01) resp_from = cyc;
      end else if (host_instruction != 8'h00) begin
        nop_viol++;
      end
      case (busy_mode)
        HOLD:    fsm_busy = 1'b1;
        RESPOND: fsm_busy = (cyc - resp_from >= 1) && (cyc - resp_from <= 4);
        default: fsm_busy = 1'b0;
      endcase
      busy_before = fsm_busy;
    end
  end

  task automatic tick;
    @(posedge clk); #2;
  endtask

  task automatic tick_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic push(input logic [7:0] w, output int e);
    logic rdy;
    int k;
    host_instr_in    = w;
    host_instr_valid = 1'b1;
    k = 0;
    do begin
      rdy = host_instr_ready;
      tick();
      k++;
    end while (!rdy && k < 200);
    host_instr_valid = 1'b0;
    e = cyc;
    check("push_accept", rdy, 1);
  endtask

  task automatic wait_issues(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (issued_w.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, issued_w.size(), n);
  endtask

  function automatic logic [7:0] ld_word(input int unsigned i);
    logic [1:0] d;
    d = 2'(i % 4);
    return {d, 6'b00_01_00};
  endfunction

  initial begin
    int e;
    int i0;
    reset = 1'b0; flush = 1'b0; host_instr_valid = 1'b0; host_instr_in = 8'h00;

    // Reset and idle
    tick(); tick();
    check("rst_instr", host_instruction, 8'h00);
    check("rst_ready", host_instr_ready, 1);
    check("rst_count", queue_count, 0);
    check("rst_err", timeout_err, 0);
    check("rst_strobe", issue_strobe, 0);
    reset = 1'b1;
    tick();
    check("idle_empty", queue_empty, 1);
    check("idle_full", queue_full, 0);

    // Single issue
    busy_mode = RESPOND;
    push(8'h45, e);
    check("single_cnt1", queue_count, 1);
    wait_issues("single_wait", 1, 10);
    check("single_val", issued_w[0], 8'h45);
    check("single_lat", issued_c[0], e + 2);
    check("single_cnt0", queue_count, 0);
    tick_to(e + 15);
    check("single_once", issued_w.size(), 1);

    // Fill and drain with busy held
    issued_w.delete(); issued_c.delete();
    busy_mode = HOLD;
    tick(); tick();
    for (int unsigned i = 0; i < 8; i++) push(ld_word(i), e);
    check("fill_full", queue_full, 1);
    check("fill_ready", host_instr_ready, 0);
    check("fill_count", queue_count, 8);
    host_instr_in = ld_word(8); host_instr_valid = 1'b1;
    tick(); tick(); tick();
    check("stall_count", queue_count, 8);
    check("stall_issue", issued_w.size(), 0);
    busy_mode = RESPOND;
    push(ld_word(8), e);
    push(ld_word(9), e);
    wait_issues("drain_wait", 10, 400);
    for (int unsigned i = 0; i < 10; i++) check("drain_order", issued_w[i], ld_word(i));
    tick_to(cyc + 10);

    // Push on the same edge as the IDLE->ISSUE pop
    issued_w.delete(); issued_c.delete();
    busy_mode = HOLD;
    tick(); tick();
    push(8'h85, e);
    tick(); tick();
    check("sim_pre_cnt", queue_count, 1);
    busy_mode = RESPOND;
    tick();
    host_instr_in = 8'hC6; host_instr_valid = 1'b1;
    tick();
    host_instr_valid = 1'b0;
    check("sim_strobe", issue_strobe, 1);
    check("sim_count", queue_count, 1);
    wait_issues("sim_wait", 2, 50);
    check("sim_first", issued_w[0], 8'h85);
    check("sim_second", issued_w[1], 8'hC6);
    tick_to(cyc + 10);

    // Flush while a command is in flight; same-cycle push is discarded
    issued_w.delete(); issued_c.delete();
    push(8'h45, e);
    tick_to(e + 2);
    check("fl_strobe", issue_strobe, 1);
    push(8'h04, e);
    push(8'h44, e);
    host_instr_in = 8'h84; host_instr_valid = 1'b1; flush = 1'b1;
    tick();
    host_instr_valid = 1'b0; flush = 1'b0;
    check("fl_count", queue_count, 0);
    check("fl_empty", queue_empty, 1);
    tick_to(cyc + 15);
    check("fl_noissue", issued_w.size(), 1);
    push(8'h86, e);
    wait_issues("fl_after_wait", 2, 10);
    check("fl_after_val", issued_w[1], 8'h86);
    check("fl_after_lat", issued_c[1], e + 2);
    tick_to(cyc + 10);

    // NOP handling
    issued_w.delete(); issued_c.delete();
    push(8'h00, e);
`ifdef QUEUE_NOP_FILTER_EN
    check("nop_count", queue_count, 0);
    tick_to(e + 20);
    check("nop_noissue", issued_w.size(), 0);
    check("nop_err", timeout_err, 0);
`else
    check("nop_count", queue_count, 1);
    wait_issues("nop_wait", 1, 10);
    check("nop_val", issued_w[0], 8'h00);
    check("nop_lat", issued_c[0], e + 2);
    i0 = issued_c[0];
    tick_to(i0 + 15);
    check("nop_err_pre", timeout_err, 0);
    tick();
    check("nop_err", timeout_err, 1);
`endif
    tick_to(cyc + 5);

    // Reset during an issue: output returns to NOP without waiting for an edge
    issued_w.delete(); issued_c.delete();
    push(8'h45, e);
    push(8'h04, i0);
    tick_to(e + 2);
    check("mr_strobe", issue_strobe, 1);
    check("mr_count", queue_count, 1);
    reset = 1'b0;
    #1;
    check("mr_instr", host_instruction, 8'h00);
    check("mr_strobe0", issue_strobe, 0);
    check("mr_count0", queue_count, 0);
    check("mr_err", timeout_err, 0);
    check("mr_ready", host_instr_ready, 1);
    tick(); tick();
    reset = 1'b1;
    busy_mode = NEVER;
    tick_to(cyc + 20);
    check("mr_lost", issued_w.size(), 1);

    // Timeout, then the next entry still issues
    issued_w.delete(); issued_c.delete();
    push(8'h07, e);
    push(8'h46, i0);
    wait_issues("to_wait", 1, 10);
    check("to_lat", issued_c[0], e + 2);
    i0 = issued_c[0];
    tick_to(i0 + TO);
    check("to_err_pre", timeout_err, 0);
    tick();
    check("to_err", timeout_err, 1);
    busy_mode = RESPOND;
    wait_issues("to_next_wait", 2, 10);
    check("to_next_val", issued_w[1], 8'h46);
    check("to_next_lat", issued_c[1], i0 + TO + 2);
    tick_to(cyc + 10);
    check("to_sticky", timeout_err, 1);

    check("nop_outside_issue", nop_viol, 0);
    check("issue_while_busy", busy_viol, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
